// File: rtl/flappy_game_state.sv
// flappy_game_state: frame-rate bird physics, pipe scrolling, collision, score and IDLE/PLAY/DEAD game FSM
module flappy_game_state #(
  parameter int BIRD_X       = 160,
  parameter int BIRD_HALF    = 10,
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = -8,
  parameter int MAX_FALL     = 8,
  parameter int PIPE_SPEED   = 2,
  parameter int PIPE_W       = 80,
  parameter int GAP          = 100,
  parameter int PIPE_SPACING = 160,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int DEAD_HOLD    = 60,
  parameter int COLLIDE_EN   = 1
) (
  input  logic              ClkPort,
  input  logic              reset,
  input  logic              vga_v_sync,
  input  logic              flap,
  output logic signed [9:0] BirdXdraw,
  output logic signed [9:0] BirdYdraw,
  output logic signed [9:0] X_Edge_O1,
  output logic signed [9:0] X_Edge_O2,
  output logic signed [9:0] X_Edge_O3,
  output logic signed [9:0] X_Edge_O4,
  output logic signed [9:0] Y_Edge_O1,
  output logic signed [9:0] Y_Edge_O2,
  output logic signed [9:0] Y_Edge_O3,
  output logic signed [9:0] Y_Edge_O4,
  output logic        [1:0] game_state,
  output logic        [7:0] score
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;
  localparam logic signed [4:0]  V_FLAP  = 5'(FLAP_VEL);
  localparam logic signed [4:0]  V_MAX   = 5'(MAX_FALL);
  localparam logic signed [4:0]  V_CAP   = 5'(MAX_FALL - GRAVITY);
  localparam logic signed [4:0]  V_G     = 5'(GRAVITY);
  localparam logic signed [9:0]  Y_INIT  = 10'(SCREEN_H / 2);
  localparam logic signed [9:0]  Y_TOP   = 10'(BIRD_HALF);
  localparam logic        [9:0]  PY_INIT = 10'd190;
  localparam logic        [9:0]  PY_BASE = 10'd80;
  localparam logic signed [11:0] C_BH    = 12'(BIRD_HALF);
  localparam logic signed [11:0] C_LO    = 12'(BIRD_X - BIRD_HALF);
  localparam logic signed [11:0] C_HI    = 12'(BIRD_X + BIRD_HALF);
  localparam logic signed [11:0] C_PW    = 12'(PIPE_W);
  localparam logic signed [11:0] C_GAP   = 12'(GAP);
  localparam logic signed [11:0] C_SH    = 12'(SCREEN_H);
  localparam logic signed [11:0] C_SPD   = 12'(PIPE_SPEED);
  localparam logic signed [11:0] C_WRAP  = 12'(4 * PIPE_SPACING);
  localparam logic        [6:0]  HOLD_MIN = 7'(DEAD_HOLD);
  localparam logic        [6:0]  HOLD_MAX = 7'd127;
  state_t            state_q, state_d;
  logic [2:0]        vs_q, vs_d, fl_q, fl_d;
  logic              tick_q, tick_d, chk_q, chk_d, pend_q, pend_d;
  logic [7:0]        lfsr_q, lfsr_d, score_q, score_d;
  logic [6:0]        hold_q, hold_d;
  logic signed [9:0] y_q, y_d;
  logic signed [4:0] vel_q, vel_d;
  logic [10:0]       px_q [4];
  logic [10:0]       px_d [4];
  logic [9:0]        py_q [4];
  logic [9:0]        py_d [4];
  logic signed [4:0]  vel_f;
  logic signed [9:0]  y_f;
  logic signed [11:0] ys;
  logic signed [11:0] x_old [4];
  logic signed [11:0] x_dec [4];
  logic signed [11:0] x_new [4];
  logic [10:0]        px_n [4];
  logic [9:0]         py_n [4];
  logic [3:0]         wrap, pass, hit;
  logic [8:0]         score_sum;
  logic [7:0]         score_n;
  logic               collide;
  // synchronize vsync/flap, form the frame tick, hold flap requests until a tick consumes them
  always_comb begin
    vs_d   = {vs_q[1:0], vga_v_sync};
    fl_d   = {fl_q[1:0], flap};
    tick_d = vs_q[2] & ~vs_q[1];
    chk_d  = tick_q;
    pend_d = (fl_q[1] & ~fl_q[2]) | (pend_q & ~tick_q);
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  // candidate PLAY update and collision test against the currently registered positions
  always_comb begin
    vel_f = pend_q ? V_FLAP : (vel_q >= V_CAP ? V_MAX : vel_q + V_G);
    y_f   = y_q + 10'(vel_f);
    ys    = 12'(y_q);
    wrap  = '0;
    pass  = '0;
    hit   = '0;
    for (int i = 0; i < 4; i++) begin
      x_old[i] = {1'b0, px_q[i]};
      x_dec[i] = x_old[i] - C_SPD;
      wrap[i]  = x_dec[i] <= 12'sd0;
      x_new[i] = wrap[i] ? x_dec[i] + C_WRAP : x_dec[i];
      px_n[i]  = x_new[i][10:0];
      py_n[i]  = wrap[i] ? PY_BASE + {2'b0, lfsr_q} : py_q[i];
      pass[i]  = (x_old[i] + C_PW >= C_LO) && (x_new[i] + C_PW < C_LO);
      hit[i]   = (x_old[i] <= C_HI) && (x_old[i] + C_PW >= C_LO) &&
                 ((ys - C_BH < $signed({2'b0, py_q[i]})) || (ys + C_BH > $signed({2'b0, py_q[i]}) + C_GAP));
    end
    score_sum = {1'b0, state_q == IDLE ? 8'd0 : score_q} + 9'(pass[0]) + 9'(pass[1]) + 9'(pass[2]) + 9'(pass[3]);
    score_n   = score_sum[8] ? 8'hFF : score_sum[7:0];
    collide   = (ys + C_BH >= C_SH) || (COLLIDE_EN != 0 && |hit);
  end
  // game FSM: positions move only on PLAY ticks; collision is judged the cycle after the tick
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    score_d = score_q;
    hold_d  = hold_q;
    px_d    = px_q;
    py_d    = py_q;
    if (tick_q && (state_q == PLAY || (state_q == IDLE && pend_q))) begin
      state_d = PLAY;
      y_d     = y_f <= Y_TOP ? Y_TOP : y_f;
      vel_d   = y_f <= Y_TOP ? 5'sd0 : vel_f;
      px_d    = px_n;
      py_d    = py_n;
      score_d = score_n;
    end else if (tick_q && state_q == DEAD) begin
      if (pend_q && hold_q >= HOLD_MIN) begin
        state_d = IDLE;
        y_d     = Y_INIT;
        vel_d   = '0;
        for (int i = 0; i < 4; i++) begin
          px_d[i] = 11'(SCREEN_W + i * PIPE_SPACING);
          py_d[i] = PY_INIT;
        end
      end else begin
        hold_d = hold_q == HOLD_MAX ? hold_q : hold_q + 7'd1;
      end
    end else if (chk_q && state_q == PLAY && collide) begin
      state_d = DEAD;
      hold_d  = '0;
    end
  end
  // state registers; reset drops every output to its idle value immediately
  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset) begin
      vs_q    <= 3'b111;
      fl_q    <= '0;
      tick_q  <= 1'b0;
      chk_q   <= 1'b0;
      pend_q  <= 1'b0;
      lfsr_q  <= 8'hA5;
      state_q <= IDLE;
      y_q     <= Y_INIT;
      vel_q   <= '0;
      score_q <= '0;
      hold_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        px_q[i] <= 11'(SCREEN_W + i * PIPE_SPACING);
        py_q[i] <= PY_INIT;
      end
    end else begin
      vs_q    <= vs_d;
      fl_q    <= fl_d;
      tick_q  <= tick_d;
      chk_q   <= chk_d;
      pend_q  <= pend_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      score_q <= score_d;
      hold_q  <= hold_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end
  function automatic logic [9:0] x_edge(input logic [10:0] x);
    return x >= 11'(SCREEN_W) ? 10'h3FF : x[9:0];
  endfunction
  assign BirdXdraw  = 10'(BIRD_X);
  assign BirdYdraw  = y_q;
  assign X_Edge_O1  = x_edge(px_q[0]);
  assign X_Edge_O2  = x_edge(px_q[1]);
  assign X_Edge_O3  = x_edge(px_q[2]);
  assign X_Edge_O4  = x_edge(px_q[3]);
  assign Y_Edge_O1  = py_q[0];
  assign Y_Edge_O2  = py_q[1];
  assign Y_Edge_O3  = py_q[2];
  assign Y_Edge_O4  = py_q[3];
  assign game_state = state_q;
  assign score      = score_q;
endmodule
